// File: rtl/kgp_ctrl_pkg.sv
// Shared encodings for the KGP_RISC multi-cycle control unit.
//   - opcode / funct field values seen from the instruction decoder
//   - control-state encoding (also exported on state_o for debug)
//   - pc_src / wb_src mux select encodings and the ALU add code
//   - legality check for the non-branch instruction classes
package kgp_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  // Opcode classes
  localparam logic [2:0] OP_RTYPE  = 3'b000;
  localparam logic [2:0] OP_IMM    = 3'b001;
  localparam logic [2:0] OP_MEM    = 3'b010;
  localparam logic [2:0] OP_BRANCH = 3'b011;
  localparam logic [2:0] OP_BR     = 3'b100;
  localparam logic [2:0] OP_COND   = 3'b101;

  // R-type funct is passed straight to the ALU: 0000 add .. 1001 shrav.
  localparam logic [3:0] F_RTYPE_MAX = 4'b1001;
  localparam logic [3:0] F_ADDI      = 4'b0000;
  localparam logic [3:0] F_COMPI     = 4'b0001;
  localparam logic [3:0] F_LW        = 4'b0000;
  localparam logic [3:0] F_SW        = 4'b0001;
  localparam logic [3:0] F_B         = 4'b0000;
  localparam logic [3:0] F_BL        = 4'b0001;
  localparam logic [3:0] F_BCY       = 4'b0010;
  localparam logic [3:0] F_BNCY      = 4'b0011;
  localparam logic [3:0] F_BLTZ      = 4'b0000;
  localparam logic [3:0] F_BZ        = 4'b0001;
  localparam logic [3:0] F_BNZ       = 4'b0010;

  localparam logic [3:0] ALU_ADD = 4'b0000;

  localparam logic [1:0] PC_SRC_SEQ   = 2'b00;  // pc + 4
  localparam logic [1:0] PC_SRC_LABEL = 2'b01;  // branch target
  localparam logic [1:0] PC_SRC_REG   = 2'b10;  // reg_1

  localparam logic [1:0] WB_SRC_ALU  = 2'b00;
  localparam logic [1:0] WB_SRC_MEM  = 2'b01;
  localparam logic [1:0] WB_SRC_LINK = 2'b10;  // pc + 4 into r31

  // Legality of ALU / memory classes; branch classes are judged by kgp_branch_resolve.
  function automatic logic alu_class_legal(input logic [2:0] op, input logic [3:0] funct);
    case (op)
      OP_RTYPE: return funct <= F_RTYPE_MAX;
      OP_IMM:   return funct inside {F_ADDI, F_COMPI};
      OP_MEM:   return funct inside {F_LW, F_SW};
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/kgp_branch_resolve.sv
// Combinational branch resolution for the KGP control unit.
// Ports:
//   op, funct                    in   latched opcode / funct of the current instruction
//   flag_zero/sign/carry         in   ALU and stored flags
//   taken                        out  branch/jump redirects the PC
//   valid                        out  op/funct is a supported branch-class encoding
module kgp_branch_resolve
  import kgp_ctrl_pkg::*;
(
  input  logic [2:0] op,
  input  logic [3:0] funct,
  input  logic       flag_zero,
  input  logic       flag_sign,
  input  logic       flag_carry,
  output logic       taken,
  output logic       valid
);

  // NOTE: every combinational output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    taken = 1'b0;
    valid = 1'b0;
    case (op)
      OP_BRANCH: begin
        case (funct)
          F_B, F_BL: begin valid = 1'b1; taken = 1'b1;        end
          F_BCY:     begin valid = 1'b1; taken = flag_carry;  end
          F_BNCY:    begin valid = 1'b1; taken = !flag_carry; end
          default:   ;
        endcase
      end
      // Register jump has no funct qualifier.
      OP_BR: begin
        valid = 1'b1;
        taken = 1'b1;
      end
      OP_COND: begin
        case (funct)
          F_BLTZ:  begin valid = 1'b1; taken = flag_sign;  end
          F_BZ:    begin valid = 1'b1; taken = flag_zero;  end
          F_BNZ:   begin valid = 1'b1; taken = !flag_zero; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/kgp_control_fsm.sv
// Multi-cycle control unit for the KGP_RISC core.
// Sequences FETCH -> DECODE -> EXEC -> {MEM} -> {WB} -> FETCH, one instruction in flight.
// Optional build macro: KGP_CTRL_PERF_EN adds cycle_cnt / instr_cnt performance counters.
// Parameters:
//   MEM_WAIT_MAX  cycles MEM waits for mem_ack before aborting (1..255)
//   PERF_W        perf counter width (only used with KGP_CTRL_PERF_EN)
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   op_code, funct_code              decoder fields, latched during DECODE
//   flag_zero/sign/carry             branch condition flags, used in EXEC only
//   mem_ack                          data memory access complete (ignored outside MEM)
//   ir_write, pc_write, pc_src       instruction register / PC update controls
//   alu_op, alu_src_imm              ALU function and B-operand select
//   reg_write, wb_src                register-file write enable and source select
//   mem_rd, mem_wr                   data memory requests, held until ack or abort
//   illegal_op, mem_err              one-cycle error pulses
//   state_o                          current state encoding (debug)
//   cycle_cnt, instr_cnt             perf counters (KGP_CTRL_PERF_EN only)
module kgp_control_fsm
  import kgp_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 16,
  parameter int PERF_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        op_code,
  input  logic [3:0]        funct_code,
  input  logic              flag_zero,
  input  logic              flag_sign,
  input  logic              flag_carry,
  input  logic              mem_ack,
  output logic              ir_write,
  output logic              pc_write,
  output logic [1:0]        pc_src,
  output logic [3:0]        alu_op,
  output logic              alu_src_imm,
  output logic              reg_write,
  output logic [1:0]        wb_src,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              illegal_op,
  output logic              mem_err,
  output logic [2:0]        state_o
`ifdef KGP_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] cycle_cnt,
  output logic [PERF_W-1:0] instr_cnt
`endif
);

  if (MEM_WAIT_MAX < 1 || MEM_WAIT_MAX > 255 || PERF_W < 1) begin : g_bad_param
    $error("kgp_control_fsm: MEM_WAIT_MAX must be 1..255 and PERF_W >= 1");
  end

  localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

  state_t     state;
  state_t     state_next;
  logic [2:0] op_q;
  logic [3:0] funct_q;
  logic [7:0] wait_cnt;
  logic       br_taken;
  logic       br_valid;
  logic       legal;
  logic       is_lw;

  kgp_branch_resolve u_branch_resolve (
    .op         (op_q),
    .funct      (funct_q),
    .flag_zero  (flag_zero),
    .flag_sign  (flag_sign),
    .flag_carry (flag_carry),
    .taken      (br_taken),
    .valid      (br_valid)
  );

  assign legal   = alu_class_legal(op_q, funct_q) | br_valid;
  assign is_lw   = (funct_q == F_LW);
  assign state_o = state;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_FETCH;
      // NOTE: op_q/funct_q are reset only for clean debug visibility; DECODE always reloads them before use.
      op_q     <= '0;
      funct_q  <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == ST_DECODE) begin
        op_q    <= op_code;
        funct_q <= funct_code;
      end
      // Counts MEM cycles without ack; cleared whenever MEM is left.
      if (state == ST_MEM && !mem_ack && wait_cnt != WAIT_MAX) begin
        wait_cnt <= wait_cnt + 8'd1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  always_comb begin
    state_next  = state;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PC_SRC_SEQ;
    alu_op      = ALU_ADD;
    alu_src_imm = 1'b0;
    reg_write   = 1'b0;
    wb_src      = WB_SRC_ALU;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    illegal_op  = 1'b0;
    mem_err     = 1'b0;

    unique case (state)
      ST_FETCH: begin
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        pc_src     = PC_SRC_SEQ;
        state_next = ST_DECODE;
      end

      ST_DECODE: state_next = ST_EXEC;

      ST_EXEC: begin
        state_next = ST_FETCH;
        if (!legal) begin
          illegal_op = 1'b1;
        end else begin
          case (op_q)
            OP_RTYPE: begin
              alu_op     = funct_q;
              state_next = ST_WB;
            end
            OP_IMM: begin
              alu_op      = funct_q;
              alu_src_imm = 1'b1;
              state_next  = ST_WB;
            end
            OP_MEM: begin
              alu_op      = ALU_ADD;
              alu_src_imm = 1'b1;
              state_next  = ST_MEM;
            end
            OP_BRANCH: begin
              pc_src   = PC_SRC_LABEL;
              pc_write = br_taken;
              if (funct_q == F_BL) state_next = ST_WB;
            end
            OP_BR: begin
              pc_src   = PC_SRC_REG;
              pc_write = br_taken;
            end
            OP_COND: begin
              pc_src   = PC_SRC_LABEL;
              pc_write = br_taken;
            end
            default: ;
          endcase
        end
      end

      ST_MEM: begin
        if (wait_cnt == WAIT_MAX) begin
          // Timeout: request already dropped this cycle, report and abandon the instruction.
          mem_err    = 1'b1;
          state_next = ST_FETCH;
        end else begin
          mem_rd = is_lw;
          mem_wr = !is_lw;
          if (mem_ack) state_next = is_lw ? ST_WB : ST_FETCH;
        end
      end

      ST_WB: begin
        reg_write  = 1'b1;
        wb_src     = (op_q == OP_MEM)    ? WB_SRC_MEM  :
                     (op_q == OP_BRANCH) ? WB_SRC_LINK : WB_SRC_ALU;
        state_next = ST_FETCH;
      end

      default: state_next = ST_FETCH;
    endcase

    // Strobes stay quiet while reset is held, even in the cycle before state returns to FETCH.
    if (rst) begin
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_src      = PC_SRC_SEQ;
      alu_op      = ALU_ADD;
      alu_src_imm = 1'b0;
      reg_write   = 1'b0;
      wb_src      = WB_SRC_ALU;
      mem_rd      = 1'b0;
      mem_wr      = 1'b0;
      illegal_op  = 1'b0;
      mem_err     = 1'b0;
    end
  end

`ifdef KGP_CTRL_PERF_EN
  logic instr_done;

  // Completed instruction: any return to FETCH except an illegal-op or timeout exit.
  assign instr_done = (state != ST_FETCH) && (state_next == ST_FETCH) && !illegal_op && !mem_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + PERF_W'(1);
      if (instr_done) instr_cnt <= instr_cnt + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_kgp_control_fsm.sv
// Self-checking bench for kgp_control_fsm.
// A driver issues instructions (directed then random), building the expected per-cycle
// output trace from the instruction-level timing rules and pushing it into a scoreboard.
// A monitor pops one entry per cycle on the falling edge and compares it with the DUT.
module tb_kgp_control_fsm;

  localparam int MEM_WAIT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] op_code = '0;
  logic [3:0] funct_code = '0;
  logic       flag_zero = 1'b0;
  logic       flag_sign = 1'b0;
  logic       flag_carry = 1'b0;
  logic       mem_ack = 1'b0;

  logic       ir_write, pc_write, alu_src_imm, reg_write;
  logic       mem_rd, mem_wr, illegal_op, mem_err;
  logic [1:0] pc_src, wb_src;
  logic [3:0] alu_op;
  logic [2:0] state_o;

  kgp_control_fsm #(.MEM_WAIT_MAX(MEM_WAIT), .PERF_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .op_code     (op_code),
    .funct_code  (funct_code),
    .flag_zero   (flag_zero),
    .flag_sign   (flag_sign),
    .flag_carry  (flag_carry),
    .mem_ack     (mem_ack),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .alu_op      (alu_op),
    .alu_src_imm (alu_src_imm),
    .reg_write   (reg_write),
    .wb_src      (wb_src),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .illegal_op  (illegal_op),
    .mem_err     (mem_err),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [3:0] alu_op;
    logic       alu_src_imm;
    logic       reg_write;
    logic [1:0] wb_src;
    logic       mem_rd;
    logic       mem_wr;
    logic       illegal_op;
    logic       mem_err;
    logic [2:0] state;
  } exp_t;

  typedef struct {
    exp_t       e;
    bit         care;
    int         idx;
    logic [2:0] op;
    logic [3:0] funct;
  } rec_t;

  rec_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   instr_idx = 0;
  exp_t got;

  // Highest supported funct per opcode (-1: opcode unsupported).
  int max_funct[8] = '{9, 1, 1, 3, 15, 2, -1, -1};

  assign got = {ir_write, pc_write, pc_src, alu_op, alu_src_imm, reg_write, wb_src,
                mem_rd, mem_wr, illegal_op, mem_err, state_o};

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock cycle of stimulus plus its expected outputs.
  task automatic step(input logic r, input logic ack, input logic fz, input logic fs, input logic fc,
                      input logic [2:0] op, input logic [3:0] funct, input exp_t e, input bit care);
    rec_t rec;
    @(posedge clk);
    #1;
    rst        = r;
    mem_ack    = ack;
    flag_zero  = fz;
    flag_sign  = fs;
    flag_carry = fc;
    op_code    = op;
    funct_code = funct;
    rec.e     = e;
    rec.care  = care;
    rec.idx   = instr_idx;
    rec.op    = op;
    rec.funct = funct;
    sb.push_back(rec);
  endtask

  // ack_wait: MEM cycle index carrying mem_ack (-1 none); reset_at: MEM cycle index where rst
  // is raised (-1 none); fz_force: flag_zero value in EXEC (-1 random).
  task automatic run_instr(input logic [2:0] op, input logic [3:0] funct, input int ack_wait,
                           input int reset_at, input int fz_force);
    exp_t       e;
    logic       legal, go_wb, go_mem, fz, fs, fc, ack, done;
    logic [1:0] wb;
    int         c;

    instr_idx++;
    legal = (int'(funct) <= max_funct[op]);

    e = '0; e.ir_write = 1'b1; e.pc_write = 1'b1; e.pc_src = 2'b00; e.state = 3'd0;
    step(1'b0, rb(), rb(), rb(), rb(), op, funct, e, 1'b1);

    e = '0; e.state = 3'd1;
    step(1'b0, rb(), rb(), rb(), rb(), op, funct, e, 1'b1);

    fz = (fz_force < 0) ? rb() : 1'(fz_force);
    fs = rb();
    fc = rb();
    e = '0; e.state = 3'd2;
    go_wb = 1'b0; go_mem = 1'b0; wb = 2'b00;
    if (!legal) begin
      e.illegal_op = 1'b1;
    end else begin
      case (op)
        3'd0: begin e.alu_op = funct; go_wb = 1'b1; wb = 2'b00; end
        3'd1: begin e.alu_op = funct; e.alu_src_imm = 1'b1; go_wb = 1'b1; wb = 2'b00; end
        3'd2: begin e.alu_op = 4'd0; e.alu_src_imm = 1'b1; go_mem = 1'b1; end
        3'd3: begin
          e.pc_src   = 2'b01;
          e.pc_write = (funct <= 4'd1) ? 1'b1 : (funct == 4'd2) ? fc : !fc;
          go_wb      = (funct == 4'd1);
          wb         = 2'b10;
        end
        3'd4: begin e.pc_src = 2'b10; e.pc_write = 1'b1; end
        default: begin
          e.pc_src   = 2'b01;
          e.pc_write = (funct == 4'd0) ? fs : (funct == 4'd1) ? fz : !fz;
        end
      endcase
    end
    step(1'b0, rb(), fz, fs, fc, op, funct, e, 1'b1);

    if (go_mem) begin
      c = 0;
      done = 1'b0;
      while (!done) begin
        if (c == reset_at) begin
          // Cycle with rst raised: state still MEM, not compared.
          e = '0; e.state = 3'd3;
          step(1'b1, 1'b0, rb(), rb(), rb(), op, funct, e, 1'b0);
          e = '0; e.state = 3'd0;
          step(1'b1, 1'b0, rb(), rb(), rb(), op, funct, e, 1'b1);
          return;
        end
        e = '0; e.state = 3'd3;
        if (c == MEM_WAIT) begin
          e.mem_err = 1'b1;
          step(1'b0, 1'b0, rb(), rb(), rb(), op, funct, e, 1'b1);
          done = 1'b1;
        end else begin
          ack = (c == ack_wait);
          e.mem_rd = (funct == 4'd0);
          e.mem_wr = (funct == 4'd1);
          step(1'b0, ack, rb(), rb(), rb(), op, funct, e, 1'b1);
          if (ack) begin
            done = 1'b1;
            if (funct == 4'd0) begin
              go_wb = 1'b1;
              wb    = 2'b01;
            end
          end
        end
        c++;
      end
    end

    if (go_wb) begin
      e = '0; e.state = 3'd4; e.reg_write = 1'b1; e.wb_src = wb;
      step(1'b0, rb(), rb(), rb(), rb(), op, funct, e, 1'b1);
    end
  endtask

  // Monitor: one scoreboard entry per cycle, sampled mid-cycle.
  initial begin
    rec_t rec;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        rec = sb.pop_front();
        if (rec.care)
          check($sformatf("i%0d_op%0d_f%0d_st%0d", rec.idx, rec.op, rec.funct, rec.e.state),
                32'(got), 32'(rec.e));
      end
    end
  end

  initial begin
    exp_t       z;
    logic [2:0] op;
    logic [3:0] funct;
    int         ack_wait, reset_at;

    z = '0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, z, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd2, 4'd0, z, 1'b1);

    run_instr(3'd0, 4'd0,  -1, -1, -1);  // add
    run_instr(3'd2, 4'd0,   2, -1, -1);  // lw, ack in 3rd MEM cycle
    run_instr(3'd2, 4'd1,  -1, -1, -1);  // sw, timeout
    run_instr(3'd5, 4'd1,  -1, -1,  1);  // bz taken
    run_instr(3'd5, 4'd1,  -1, -1,  0);  // bz not taken
    run_instr(3'd3, 4'd1,  -1, -1, -1);  // bl
    run_instr(3'd7, 4'd0,  -1, -1, -1);  // unsupported opcode
    run_instr(3'd0, 4'd10, -1, -1, -1);  // R-type funct beyond shrav
    run_instr(3'd4, 4'd5,  -1, -1, -1);  // br
    run_instr(3'd2, 4'd0,  -1,  4, -1);  // reset during lw wait
    run_instr(3'd2, 4'd1,   0, -1, -1);  // sw, immediate ack
    run_instr(3'd2, 4'd0,  15, -1, -1);  // lw, ack on last cycle before timeout
    run_instr(3'd1, 4'd1,  -1, -1, -1);  // compi

    for (int n = 0; n < 200; n++) begin
      op = 3'($urandom_range(0, 7));
      if (max_funct[op] >= 0 && $urandom_range(0, 3) != 0)
        funct = 4'($urandom_range(0, max_funct[op]));
      else
        funct = 4'($urandom_range(0, 15));
      ack_wait = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 17));
      reset_at = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 10)) : -1;
      run_instr(op, funct, ack_wait, reset_at, -1);
    end

    @(negedge clk);
    #1;
    for (int i = 0; i < 5 && sb.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    check("scoreboard_drain", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
